autocorr_engine: RTL and testbench

AUTOCORR_ENGINE -- requirements
Module: autocorr_engine

---
 rtl/autocorr_pkg.sv | 25 ++
 rtl/autocorr_if.sv | 27 ++
 rtl/sample_buffer.sv | 27 ++
 rtl/autocorr_engine.sv | 122 ++++++++++++
 tb/tb_autocorr_engine.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/autocorr_pkg.sv
// rtl/autocorr_pkg.sv - shared sizes, types and state encoding for the autocorrelation engine
package autocorr_pkg;

    localparam int N_SAMPLES = 480;
    localparam int LAG_MIN   = 47;
    localparam int LAG_MAX   = 141;
    localparam int SAMPLE_W  = 16;
    localparam int RESULT_W  = 72;
    localparam int CNT_W     = 10;
    localparam int ADDR_W    = $clog2(N_SAMPLES);
    localparam int N_LAGS    = LAG_MAX - LAG_MIN + 1;
    localparam int LAG_W     = $clog2(N_LAGS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [RESULT_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        MAC,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/autocorr_if.sv
// rtl/autocorr_if.sv - sample stream in, autocorrelation array and completion flag out
interface autocorr_if;
    import autocorr_pkg::*;

    logic    frame_start;
    sample_t sample_in;
    logic    sample_valid;
    result_t fout [N_SAMPLES];
    logic    shouldFind;

    modport master (
        output frame_start,
        output sample_in,
        output sample_valid,
        input  fout,
        input  shouldFind
    );

    modport slave (
        input  frame_start,
        input  sample_in,
        input  sample_valid,
        output fout,
        output shouldFind
    );

endinterface

// File: rtl/sample_buffer.sv
// rtl/sample_buffer.sv - frame sample store, one synchronous write port and two combinational reads
module sample_buffer
    import autocorr_pkg::*;
(
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  sample_t           wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output sample_t           rdata_a,
    output sample_t           rdata_b
);

    sample_t mem [N_SAMPLES];

    // Contents are never reset; only the current frame's writes matter.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/autocorr_engine.sv
// rtl/autocorr_engine.sv - frame capture followed by lag-serial multiply-accumulate autocorrelation
module autocorr_engine
    import autocorr_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    autocorr_if.slave  bus
);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     n;
    logic [CNT_W-1:0]     k;
    result_t              acc;
    result_t              res [N_LAGS];
    logic                 should_find;

    sample_t              x_n;
    sample_t              x_nk;
    logic signed [2*SAMPLE_W-1:0] prod;
    logic                 buf_we;
    logic [ADDR_W-1:0]    buf_waddr;
    logic [LAG_W-1:0]     lag_idx;

    // A frame_start always restarts the fill at x[0], even mid-frame.
    assign buf_we    = !Reset && bus.sample_valid && (bus.frame_start || state == FILL);
    assign buf_waddr = bus.frame_start ? '0 : count[ADDR_W-1:0];
    assign prod      = $signed(32'(x_n)) * $signed(32'(x_nk));
    assign lag_idx   = LAG_W'(k - CNT_W'(LAG_MIN));

    sample_buffer u_sample_buffer (
        .Clk     (Clk),
        .we      (buf_we),
        .waddr   (buf_waddr),
        .wdata   (bus.sample_in),
        .raddr_a (n[ADDR_W-1:0]),
        .raddr_b (ADDR_W'(n + k)),
        .rdata_a (x_n),
        .rdata_b (x_nk)
    );

    // Control FSM: fill the buffer, then one MAC pass plus one WRITE cycle per lag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            should_find <= 1'b0;
            count       <= '0;
            n           <= '0;
            k           <= '0;
            acc         <= '0;
            for (int i = 0; i < N_LAGS; i++) begin
                res[i] <= '0;
            end
        end else if (bus.frame_start) begin
            state       <= FILL;
            should_find <= 1'b0;
            count       <= bus.sample_valid ? CNT_W'(1) : '0;
            n           <= '0;
            k           <= '0;
            acc         <= '0;
            for (int i = 0; i < N_LAGS; i++) begin
                res[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                FILL: begin
                    if (bus.sample_valid) begin
                        count <= count + 1'b1;
                        if (count == CNT_W'(N_SAMPLES - 1)) begin
                            state <= MAC;
                            k     <= CNT_W'(LAG_MIN);
                            n     <= '0;
                            acc   <= '0;
                        end
                    end
                end
                MAC: begin
                    // Products are sign-extended to the full accumulator width.
                    acc <= acc + {{(RESULT_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod};
                    if (n == CNT_W'(N_SAMPLES - 1) - k) begin
                        state <= WRITE;
                    end else begin
                        n <= n + 1'b1;
                    end
                end
                WRITE: begin
                    res[lag_idx] <= acc;
                    acc          <= '0;
                    if (k == CNT_W'(LAG_MAX)) begin
                        state       <= DONE;
                        should_find <= 1'b1;
                    end else begin
                        k     <= k + 1'b1;
                        n     <= '0;
                        state <= MAC;
                    end
                end
                DONE: begin
                end
                default: begin
                    state       <= IDLE;
                    should_find <= 1'b0;
                end
            endcase
        end
    end

    // Only lags LAG_MIN..LAG_MAX have storage; every other entry reads zero.
    always_comb begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            bus.fout[i] = '0;
        end
        for (int j = 0; j < N_LAGS; j++) begin
            bus.fout[LAG_MIN + j] = res[j];
        end
    end

    assign bus.shouldFind = should_find;

endmodule

// File: tb/tb_autocorr_engine.sv
// tb/tb_autocorr_engine.sv - randomized frames against a direct-sum reference with a scoreboard monitor
module tb_autocorr_engine;
    import autocorr_pkg::*;

    localparam int TOTAL_CYC = 36765;

    logic Clk = 1'b0;
    logic Reset;

    autocorr_if bus ();

    autocorr_engine dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int     checks   = 0;
    int     failures = 0;
    int     xbuf [N_SAMPLES];
    longint exp_mem [3][N_SAMPLES];
    int     id_q [$];
    int     due_q [$];
    logic   prev_sf = 1'b0;

    // Reference: r[k] = sum over n of x[n]*x[n+k], zero outside the computed lag range.
    function automatic longint ref_lag(int k);
        longint s = 0;
        if (k < LAG_MIN || k > LAG_MAX) return 0;
        for (int i = 0; i + k < N_SAMPLES; i++) begin
            s += longint'(xbuf[i]) * longint'(xbuf[i + k]);
        end
        return s;
    endfunction

    task automatic build_model(input int id);
        for (int k = 0; k < N_SAMPLES; k++) exp_mem[id][k] = ref_lag(k);
    endtask

    function automatic result_t ext(input longint v);
        return {{(RESULT_W-64){v[63]}}, v};
    endfunction

    task automatic check_res(input string name, input int idx, input result_t act, input result_t expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_frame(input string name, input int id, input int upto_lag);
        for (int k = 0; k < N_SAMPLES; k++) begin
            check_res(name, k, bus.fout[k], (k <= upto_lag) ? ext(exp_mem[id][k]) : '0);
        end
    endtask

    task automatic check_zero(input string name);
        for (int k = 0; k < N_SAMPLES; k++) check_res(name, k, bus.fout[k], '0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Sends xbuf[0..nsamp-1] with random idle gaps; returns the edge count after the last store.
    task automatic send_frame(input bit with_start, input int nsamp, output int last_edge);
        for (int i = 0; i < nsamp; i++) begin
            if (i != 0) begin
                while ($urandom_range(0, 7) == 0) begin
                    bus.sample_valid = 1'b0;
                    bus.sample_in    = 16'($urandom);
                    tick();
                end
            end
            bus.frame_start  = with_start && (i == 0);
            bus.sample_valid = 1'b1;
            bus.sample_in    = 16'(xbuf[i]);
            tick();
        end
        bus.frame_start  = 1'b0;
        bus.sample_valid = 1'b0;
        last_edge = cyc;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < TOTAL_CYC + 2000; i++) begin
            if (bus.shouldFind) break;
            @(negedge Clk);
        end
        if (!bus.shouldFind) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for shouldFind", name);
        end
    endtask

    task automatic noise_pulses(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.sample_in    = 16'($urandom);
            tick();
        end
        bus.sample_valid = 1'b0;
    endtask

    // Monitor: on each shouldFind rise, pop the expected frame and its due cycle.
    always @(negedge Clk) begin
        if (bus.shouldFind === 1'b1 && prev_sf !== 1'b1) begin
            if (id_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d expected no completion", cyc);
            end else begin
                int id;
                int due;
                id  = id_q.pop_front();
                due = due_q.pop_front();
                check_int("done_latency", cyc, due);
                check_frame("fout_done", id, LAG_MAX);
            end
        end
        prev_sf = bus.shouldFind;
    end

    initial begin
        int e;
        logic signed [15:0] t;

        Reset            = 1'b1;
        bus.frame_start  = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        repeat (3) tick();
        Reset = 1'b0;
        check_int("reset_shouldFind", int'(bus.shouldFind), 0);
        check_zero("fout_reset");
        noise_pulses(5);

        // Frame A: random data, aborted by frame_start partway through lag 80.
        for (int i = 0; i < N_SAMPLES; i++) begin
            t = 16'($urandom);
            if ($urandom_range(0, 15) == 0) t = 16'sh8000;
            xbuf[i] = t;
        end
        build_model(0);
        send_frame(1'b1, N_SAMPLES, e);
        while (cyc < e + 13893) tick();
        check_int("partial_shouldFind", int'(bus.shouldFind), 0);
        check_frame("fout_partial", 0, 79);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check_int("abort_shouldFind", int'(bus.shouldFind), 0);
        check_zero("fout_abort");

        // Frame B: all -32768 into the fill the abort just opened; worst-case magnitude.
        for (int i = 0; i < N_SAMPLES; i++) xbuf[i] = -32768;
        build_model(1);
        send_frame(1'b0, N_SAMPLES, e);
        id_q.push_back(1);
        due_q.push_back(e + TOTAL_CYC);
        wait_done("frame_b");
        check_res("fout47_neg", 47, bus.fout[47], 72'sd464930209792);
        noise_pulses(8);
        check_int("done_hold_shouldFind", int'(bus.shouldFind), 1);
        check_frame("fout_done_hold", 1, LAG_MAX);

        // Reset wins over a simultaneous frame_start and sample_valid.
        Reset            = 1'b1;
        bus.frame_start  = 1'b1;
        bus.sample_valid = 1'b1;
        tick();
        Reset            = 1'b0;
        bus.frame_start  = 1'b0;
        bus.sample_valid = 1'b0;
        check_int("reset_done_shouldFind", int'(bus.shouldFind), 0);
        check_zero("fout_reset_done");
        for (int i = 0; i < N_SAMPLES; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 16'($urandom_range(1, 30000));
            tick();
        end
        bus.sample_valid = 1'b0;
        repeat (450) tick();
        check_int("idle_shouldFind", int'(bus.shouldFind), 0);
        check_zero("fout_idle");

        // Frame C: reset after 200 samples, then a full frame of 2 with noise during MAC.
        for (int i = 0; i < N_SAMPLES; i++) xbuf[i] = int'($urandom_range(0, 65535)) - 32768;
        send_frame(1'b1, 200, e);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        noise_pulses(6);
        for (int i = 0; i < N_SAMPLES; i++) xbuf[i] = 2;
        build_model(2);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        send_frame(1'b0, N_SAMPLES, e);
        id_q.push_back(2);
        due_q.push_back(e + TOTAL_CYC);
        noise_pulses(300);
        wait_done("frame_c");
        check_res("fout47_twos", 47, bus.fout[47], 72'sd1732);
        noise_pulses(8);
        check_frame("fout_done_hold_c", 2, LAG_MAX);
        tick();
        check_int("pending_frames", id_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
